muldiv_unit: RTL and testbench

//  Iterative RV32M multiply/divide unit fed by the register file read ports (rs1/rs2 data).

---
 rtl/muldiv_pkg.sv | 21 ++
 rtl/muldiv_unit.sv | 148 ++++++++++++++
 tb/tb_muldiv_unit.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared constants for the iterative RV32M multiply/divide unit:
// funct3 opcodes, FSM state encodings and the default datapath width.
package muldiv_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one bit per cycle over a shared
// acc_hi:acc_lo shift datapath, sign correction in FIX, one-cycle done pulse.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = $clog2(XLEN);

  logic [1:0]      state_q,   state_d;
  logic [CW-1:0]   cnt_q,     cnt_d;
  logic [2:0]      funct3_q,  funct3_d;
  logic [XLEN-1:0] acc_hi_q,  acc_hi_d;
  logic [XLEN-1:0] acc_lo_q,  acc_lo_d;
  logic [XLEN-1:0] mcand_q,   mcand_d;
  logic            neg_quo_q, neg_quo_d;
  logic            neg_rem_q, neg_rem_d;
  logic [XLEN-1:0] result_q,  result_d;

  logic              signed_a, signed_b, sign_a, sign_b;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic              div_zero, div_ovf;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  always_comb begin
    signed_a = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
               (funct3 == F3_DIV)  || (funct3 == F3_REM);
    signed_b = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
    sign_a   = signed_a & op_a[XLEN-1];
    sign_b   = signed_b & op_b[XLEN-1];
    mag_a    = sign_a ? (~op_a + 1'b1) : op_a;
    mag_b    = sign_b ? (~op_b + 1'b1) : op_b;
    div_zero = funct3[2] && (op_b == '0);
    div_ovf  = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
               (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);

    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : '0);
    div_shift = {acc_hi_q, acc_lo_q[XLEN-1]};

    prod     = {acc_hi_q, acc_lo_q};
    prod_fix = neg_quo_q ? (~prod + 1'b1) : prod;
    quo_fix  = neg_quo_q ? (~acc_lo_q + 1'b1) : acc_lo_q;
    rem_fix  = neg_rem_q ? (~acc_hi_q + 1'b1) : acc_hi_q;

    state_d   = state_q;
    cnt_d     = cnt_q;
    funct3_d  = funct3_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    mcand_d   = mcand_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (!start) begin
          state_d = S_IDLE;
        end else if (div_zero) begin
          state_d  = S_DONE;
          result_d = funct3[1] ? op_a : '1;
        end else if (div_ovf) begin
          state_d  = S_DONE;
          result_d = funct3[1] ? '0 : op_a;
        end else begin
          // Multiply keeps the multiplier in acc_lo; divide keeps the dividend there.
          state_d   = S_CALC;
          cnt_d     = '0;
          funct3_d  = funct3;
          acc_hi_d  = '0;
          acc_lo_d  = funct3[2] ? mag_a : mag_b;
          mcand_d   = funct3[2] ? mag_b : mag_a;
          neg_quo_d = sign_a ^ sign_b;
          neg_rem_d = sign_a;
        end
      end
      S_CALC: begin
        if (funct3_q[2]) begin
          if (div_shift >= {1'b0, mcand_q}) begin
            acc_hi_d = div_shift[XLEN-1:0] - mcand_q;
            acc_lo_d = {acc_lo_q[XLEN-2:0], 1'b1};
          end else begin
            acc_hi_d = div_shift[XLEN-1:0];
            acc_lo_d = {acc_lo_q[XLEN-2:0], 1'b0};
          end
        end else begin
          {acc_hi_d, acc_lo_d} = {mul_sum, acc_lo_q[XLEN-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(XLEN-1)) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_DONE;
        case (funct3_q)
          F3_MUL:                    result_d = prod_fix[XLEN-1:0];
          F3_MULH, F3_MULHSU,
          F3_MULHU:                  result_d = prod_fix[2*XLEN-1:XLEN];
          F3_DIV, F3_DIVU:           result_d = quo_fix;
          default:                   result_d = rem_fix;
        endcase
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      funct3_q  <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      mcand_q   <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      funct3_q  <= funct3_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      mcand_q   <= mcand_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

  assign busy   = (state_q == S_CALC) || (state_q == S_FIX);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: launches push expected result and done
// cycle; a negedge monitor pops and compares on every done pulse.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic        busy, done;
  logic [31:0] result;

  typedef struct {
    logic [31:0] res;
    int          cyc;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected no pending op", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_result"}, result, e.res);
        chk({e.name, "_done_cycle"}, 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Call at a negedge; drives one start pulse sampled by the next posedge.
  task automatic launch(string name, logic [2:0] f, logic [31:0] a, logic [31:0] b,
                        logic [31:0] exp, bit special);
    exp_t e;
    funct3 = f;
    op_a   = a;
    op_b   = b;
    start  = 1'b1;
    e.res  = exp;
    e.cyc  = cyc + (special ? 1 : 34);
    e.name = name;
    sb.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 40);
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got no done after %0d cycles expected done", name, n);
      sb.delete();
    end
  endtask

  task automatic run_op(string name, logic [2:0] f, logic [31:0] a, logic [31:0] b,
                        logic [31:0] exp, bit special);
    @(negedge clk);
    launch(name, f, a, b, exp, special);
    wait_done(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    funct3 = '0;
    op_a   = '0;
    op_b   = '0;
    repeat (2) @(negedge clk);
    chk("reset_result", result, 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;

    run_op("mul_7_m3",     3'd0, 32'd7,         32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0);
    run_op("mulh_min",     3'd1, 32'h80000000,  32'h80000000, 32'h40000000, 1'b0);
    run_op("mulh_3_m5",    3'd1, 32'd3,         32'hFFFFFFFB, 32'hFFFFFFFF, 1'b0);
    run_op("mulhu_max",    3'd3, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
    run_op("mulhsu_m1_2",  3'd2, 32'hFFFFFFFF,  32'd2,        32'hFFFFFFFF, 1'b0);
    run_op("div_m7_2",     3'd4, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFD, 1'b0);
    run_op("rem_m7_2",     3'd6, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFF, 1'b0);
    run_op("div_7_m2",     3'd4, 32'd7,         32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0);
    run_op("rem_7_m2",     3'd6, 32'd7,         32'hFFFFFFFE, 32'h00000001, 1'b0);
    run_op("divu_100_7",   3'd5, 32'd100,       32'd7,        32'd14,       1'b0);
    run_op("remu_100_7",   3'd7, 32'd100,       32'd7,        32'd2,        1'b0);
    run_op("div_5_0",      3'd4, 32'd5,         32'd0,        32'hFFFFFFFF, 1'b1);
    run_op("remu_5_0",     3'd7, 32'd5,         32'd0,        32'd5,        1'b1);
    run_op("div_ovf",      3'd4, 32'h80000000,  32'hFFFFFFFF, 32'h80000000, 1'b1);
    run_op("rem_ovf",      3'd6, 32'h80000000,  32'hFFFFFFFF, 32'h00000000, 1'b1);

    // Stray start mid-divide must not relatch operands or restart.
    @(negedge clk);
    launch("divu_ignore", 3'd5, 32'd1000, 32'd10, 32'd100, 1'b0);
    repeat (9) @(negedge clk);
    chk("busy_in_calc", 32'(busy), 32'h1);
    funct3 = 3'd7;
    op_a   = 32'd9;
    op_b   = 32'd3;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("divu_ignore");
    // Still at the done cycle: start here is back-to-back.
    launch("remu_b2b", 3'd7, 32'd1000, 32'd7, 32'd6, 1'b0);
    wait_done("remu_b2b");

    // Async reset mid-multiply abandons the op.
    @(negedge clk);
    funct3 = 3'd0;
    op_a   = 32'h1234;
    op_b   = 32'h10;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (14) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_done", 32'(done), 32'h0);
    chk("abort_result", result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("mul_after_rst", 3'd0, 32'h1234, 32'h10, 32'h00012340, 1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
